// File: rtl/signal_pkg.sv
// Shared types for the intersection phase sequencer and the LED-matrix display block.
package signal_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        LT_RED = 2'b00,
        LT_GRN = 2'b01,
        LT_YEL = 2'b10
    } light_t;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_CLEAR  = 2'd3
    } phase_t;

    function automatic logic [3:0] dir_onehot(input logic [1:0] d);
        return 4'b0001 << d;
    endfunction

endpackage

// File: rtl/signal_phase_scheduler_rr_arbiter4.sv
// Four-way round-robin picker: first available approach at or after ptr, wrapping mod 4.
module rr_arbiter4 (
    input  logic [3:0] avail,
    input  logic [1:0] ptr,
    output logic       grant_valid,
    output logic [1:0] grant_dir
);

    // Walk from farthest to nearest so the closest hit to ptr is the last write.
    always_comb begin
        grant_valid = 1'b0;
        grant_dir   = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (avail[ptr + 2'(k)]) begin
                grant_valid = 1'b1;
                grant_dir   = ptr + 2'(k);
            end
        end
    end

endmodule

// File: rtl/signal_phase_scheduler.sv
// Four-way intersection phase sequencer: latches requests, grants round-robin and times
// green/yellow/all-red against an external tick, with emergency preempt.
module signal_phase_scheduler
    import signal_pkg::*;
#(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic       preempt,
    output logic [7:0] light,
    output logic [1:0] active_dir,
    output logic [3:0] served,
    output logic [1:0] phase
);

    localparam logic [CNT_W:0] L_GMIN = (CNT_W+1)'(GREEN_MIN);
    localparam logic [CNT_W:0] L_GMAX = (CNT_W+1)'(GREEN_MAX);
    localparam logic [CNT_W:0] L_YEL  = (CNT_W+1)'(YELLOW_T);
    localparam logic [CNT_W:0] L_AR   = (CNT_W+1)'(ALLRED_T);

    phase_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_pending, w_pending_nxt;
    logic [1:0]       r_ptr, r_active;
    logic             r_new_green;
    logic [7:0]       r_light, w_light;
    logic [1:0]       r_active_dir, r_phase;
    logic [3:0]       r_served;

    logic [3:0]       w_avail, w_others;
    logic             w_gv, w_grant;
    logic [1:0]       w_gdir;
    logic [CNT_W:0]   w_t;

    assign w_avail  = r_pending | req;
    assign w_others = w_avail & ~dir_onehot(r_active);
    // One extra bit so the limit compare fires before the counter could wrap.
    assign w_t      = {1'b0, r_cnt} + (CNT_W+1)'(1);

    rr_arbiter4 u_arb (
        .avail       (w_avail),
        .ptr         (r_ptr),
        .grant_valid (w_gv),
        .grant_dir   (w_gdir)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        case (r_state)
            PH_IDLE: begin
                if (w_gv && !preempt) w_grant = 1'b1;
            end
            PH_GREEN: begin
                if (preempt) begin
                    w_state_nxt = PH_YELLOW;
                    w_cnt_nxt   = '0;
                end else if (tick) begin
                    if (w_t >= L_GMAX ||
                        (w_t >= L_GMIN && (!req[r_active] || w_others != 4'b0000))) begin
                        w_state_nxt = PH_YELLOW;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_t[CNT_W-1:0];
                    end
                end
            end
            PH_YELLOW: begin
                if (tick) begin
                    if (w_t >= L_YEL) begin
                        w_state_nxt = PH_CLEAR;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_t[CNT_W-1:0];
                    end
                end
            end
            PH_CLEAR: begin
                if (tick) begin
                    if (w_t >= L_AR) begin
                        if (w_gv && !preempt) begin
                            w_grant = 1'b1;
                        end else begin
                            w_state_nxt = PH_IDLE;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_cnt_nxt = w_t[CNT_W-1:0];
                    end
                end
            end
            default: ;
        endcase
        if (w_grant) begin
            w_state_nxt = PH_GREEN;
            w_cnt_nxt   = '0;
        end
    end

    // A grant clears its own pending bit even if req sets it on the same edge.
    assign w_pending_nxt = w_avail & ~(w_grant ? dir_onehot(w_gdir) : 4'b0000);

    always_comb begin
        w_light = '0;
        for (int d = 0; d < 4; d++) begin
            w_light[2*d +: 2] = LT_RED;
            if (2'(d) == r_active) begin
                if (r_state == PH_GREEN)       w_light[2*d +: 2] = LT_GRN;
                else if (r_state == PH_YELLOW) w_light[2*d +: 2] = LT_YEL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= PH_IDLE;
            r_cnt        <= '0;
            r_pending    <= '0;
            r_ptr        <= '0;
            r_active     <= '0;
            r_new_green  <= 1'b0;
            r_light      <= '0;
            r_active_dir <= '0;
            r_served     <= '0;
            r_phase      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pending   <= w_pending_nxt;
            r_new_green <= w_grant;
            if (w_grant) begin
                r_active <= w_gdir;
                r_ptr    <= w_gdir + 2'd1;
            end
            r_light      <= w_light;
            r_active_dir <= r_active;
            r_served     <= r_new_green ? dir_onehot(r_active) : 4'b0000;
            r_phase      <= r_state;
        end
    end

    assign light      = r_light;
    assign active_dir = r_active_dir;
    assign served     = r_served;
    assign phase      = r_phase;

endmodule

// File: tb/tb_signal_phase_scheduler.sv
// Bench for signal_phase_scheduler: vector table, directed corner sequences and random traffic vs a reference model.
module tb_signal_phase_scheduler;

    localparam int GMIN = 4;
    localparam int GMAX = 12;
    localparam int YT   = 2;
    localparam int AR   = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [3:0] req;
    logic       preempt;
    logic [7:0] light;
    logic [1:0] active_dir;
    logic [3:0] served;
    logic [1:0] phase;

    int checks = 0;
    int errors = 0;

    // Reference model: phase index, ticks elapsed in phase, rr pointer, current approach.
    int         m_st, m_cnt, m_ptr, m_act;
    logic [3:0] m_pend;
    bit         m_fresh;

    typedef struct {
        logic [3:0] req;
        logic [7:0] light;
        logic [1:0] phase;
        logic [3:0] served;
    } vec_t;

    always #5 clk = ~clk;

    signal_phase_scheduler #(
        .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT), .ALLRED_T(AR), .CNT_W(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .req        (req),
        .preempt    (preempt),
        .light      (light),
        .active_dir (active_dir),
        .served     (served),
        .phase      (phase)
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_st = 0; m_cnt = 0; m_ptr = 0; m_act = 0; m_pend = 4'b0; m_fresh = 0;
    endtask

    function automatic int m_pick(input logic [3:0] av);
        for (int k = 0; k < 4; k++)
            if (av[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    task automatic m_advance(input logic [3:0] r, input logic t, input logic p);
        logic [3:0] av;
        int d, e;
        bit ok, g;
        av = m_pend | r;
        d  = m_pick(av);
        ok = (d >= 0) && !p;
        g  = 0;
        e  = m_cnt + 1;
        m_fresh = 0;
        case (m_st)
            0: if (ok) g = 1;
            1: begin
                if (p) begin
                    m_st = 2; m_cnt = 0;
                end else if (t) begin
                    if (e >= GMAX || (e >= GMIN && (!r[m_act] || (av & ~(4'b0001 << m_act)) != 0))) begin
                        m_st = 2; m_cnt = 0;
                    end else m_cnt = e;
                end
            end
            2: if (t) begin
                if (e >= YT) begin m_st = 3; m_cnt = 0; end else m_cnt = e;
            end
            default: if (t) begin
                if (e >= AR) begin
                    if (ok) g = 1;
                    else begin m_st = 0; m_cnt = 0; end
                end else m_cnt = e;
            end
        endcase
        m_pend = av;
        if (g) begin
            m_st = 1; m_cnt = 0; m_act = d; m_ptr = (d + 1) % 4; m_fresh = 1;
            m_pend[d] = 1'b0;
        end
    endtask

    // Outputs are registered, so what is visible after an edge reflects the model state before it.
    task automatic step(input logic [3:0] r, input logic t, input logic p);
        logic [7:0] el;
        logic [3:0] es;
        int ep, ea;
        req = r; tick = t; preempt = p;
        el = 8'h00;
        if (m_st == 1)      el[2*m_act +: 2] = 2'b01;
        else if (m_st == 2) el[2*m_act +: 2] = 2'b10;
        ep = m_st;
        ea = m_act;
        es = m_fresh ? 4'(1 << m_act) : 4'd0;
        m_advance(r, t, p);
        @(posedge clk);
        #1;
        check("model_light", light, el);
        check("model_phase", phase, ep);
        check("model_served", served, es);
        check("model_active_dir", active_dir, ea);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 4'b0; tick = 1'b0; preempt = 1'b0;
        #10;
        rst_n = 1'b1;
        m_reset();
    endtask

    function automatic int first_dir(input logic [3:0] s);
        for (int k = 0; k < 4; k++) if (s[k]) return k;
        return -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[10];
        int   q[$];
        int   greens, yel_cnt, fd;
        bit   bad, saw_idle;
        logic pst;

        tbl[0] = '{4'b0001, 8'h00, 2'd0, 4'b0000};
        tbl[1] = '{4'b0000, 8'h01, 2'd1, 4'b0001};
        tbl[2] = '{4'b0000, 8'h01, 2'd1, 4'b0000};
        tbl[3] = '{4'b0000, 8'h01, 2'd1, 4'b0000};
        tbl[4] = '{4'b0000, 8'h01, 2'd1, 4'b0000};
        tbl[5] = '{4'b0000, 8'h02, 2'd2, 4'b0000};
        tbl[6] = '{4'b0000, 8'h02, 2'd2, 4'b0000};
        tbl[7] = '{4'b0000, 8'h00, 2'd3, 4'b0000};
        tbl[8] = '{4'b0000, 8'h00, 2'd0, 4'b0000};
        tbl[9] = '{4'b0000, 8'h00, 2'd0, 4'b0000};

        rst_n = 1'b0; req = 4'b0; tick = 1'b0; preempt = 1'b0;
        m_reset();
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_light", light, 8'h00);
        check("reset_phase", phase, 0);
        check("reset_served", served, 0);
        check("reset_active_dir", active_dir, 0);

        // Idle with no requests
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0000, 1'b1, 1'b0);
            if (phase != 2'd0 || light != 8'h00 || served != 4'b0) bad = 1;
        end
        check("idle_quiet", bad, 0);

        // Gap-out after a one-cycle north request
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].req, 1'b1, 1'b0);
            check($sformatf("tbl%0d_light", i), light, tbl[i].light);
            check($sformatf("tbl%0d_phase", i), phase, tbl[i].phase);
            check($sformatf("tbl%0d_served", i), served, tbl[i].served);
        end

        // Max-out with east held, then re-grant straight from all-red
        do_reset();
        greens = 0; saw_idle = 0;
        step(4'b0010, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step(4'b0010, 1'b1, 1'b0);
            if (i <= 15 && light == 8'h04) greens++;
            if (phase == 2'd0) saw_idle = 1;
            if (i == 13) check("maxout_yellow", light, 8'h08);
            if (i == 15) check("maxout_clear_phase", phase, 3);
            if (i == 16) begin
                check("maxout_regrant_light", light, 8'h04);
                check("maxout_regrant_served", served, 4'b0010);
            end
        end
        check("maxout_green_cycles", greens, GMAX);
        check("maxout_no_idle", saw_idle, 0);

        // Round-robin: N+S together, then W+N together
        do_reset();
        q.delete();
        step(4'b0101, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            step(4'b0000, 1'b1, 1'b0);
            fd = first_dir(served);
            if (fd >= 0) q.push_back(fd);
        end
        check("rr1_count", q.size(), 2);
        if (q.size() == 2) begin
            check("rr1_first", q[0], 0);
            check("rr1_second", q[1], 2);
        end
        check("rr1_idle", phase, 0);
        q.delete();
        step(4'b1001, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            step(4'b0000, 1'b1, 1'b0);
            fd = first_dir(served);
            if (fd >= 0) q.push_back(fd);
        end
        check("rr2_count", q.size(), 2);
        if (q.size() == 2) begin
            check("rr2_first", q[0], 3);
            check("rr2_second", q[1], 0);
        end

        // Preempt during north green with east pending
        do_reset();
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b1);
        check("pre_still_green", light, 8'h01);
        yel_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(4'b0000, 1'b1, 1'b1);
            if (light == 8'h02) yel_cnt++;
        end
        check("pre_yellow_cycles", yel_cnt, YT);
        check("pre_hold_phase", phase, 0);
        check("pre_hold_light", light, 8'h00);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check("pre_release_light", light, 8'h04);
        check("pre_release_served", served, 4'b0010);

        // Asynchronous reset in the middle of yellow
        do_reset();
        step(4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        check("areset_pre_yellow", light, 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_light", light, 8'h00);
        check("areset_phase", phase, 0);
        m_reset();
        #3;
        rst_n = 1'b1;
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check("areset_pending_clr", phase, 0);
        step(4'b1000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check("areset_w_light", light, 8'h40);
        check("areset_w_dir", active_dir, 3);

        // Random traffic, ticks and preempt bursts
        do_reset();
        pst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 60) == 0) pst = ~pst;
            step(($urandom_range(0, 6) == 0) ? 4'($urandom) : 4'b0000,
                 $urandom_range(0, 2) != 0, pst);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
